// File: rtl/dev_debug_output_pkg.sv
// Shared register map, bit positions and default depth for the debug output device.
package dev_debug_output_pkg;

    localparam int DEFAULT_DEPTH = 8;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_DRAINED   = 3;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/dev_debug_output_sync_fifo.sv
// Generic single-clock FIFO with flush; a push into a full FIFO is honoured only
// when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gated so the head reads zero out of reset without clearing the storage array.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dev_debug_output.sv
// Memory-mapped debug output device: CPU pushes words, a console port drains them.
// Optional drain interrupt enabled by defining DEV_DEBUG_OUTPUT_IRQ_EN.
module dev_debug_output
    import dev_debug_output_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          wr_data;
    logic          wr_ctrl;
    logic          rd_status;
    logic          flush;
    logic          pop;
    logic          push_ok;
    logic          ovf;
    logic          irq_en;
    logic          drained;

    assign wr_data   = we && (addr == REG_DATA);
    assign wr_ctrl   = we && (addr == REG_CTRL);
    assign rd_status = re && (addr == REG_STATUS);
    assign flush     = wr_ctrl && din[CTRL_FLUSH];

    // Console handshake: out_data is offered while out_valid is high and is held
    // stable until the consumer raises out_ready; a word transfers on each edge
    // where both are high, and neither signal depends combinationally on out_ready.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push_ok   = wr_data && (!full || pop);

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .head  (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A fresh overflow outranks a clearing STATUS read; flush outranks both.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf <= 1'b0;
        end else if (wr_data && !push_ok) begin
            ovf <= 1'b1;
        end else if (rd_status) begin
            ovf <= 1'b0;
        end
    end

`ifdef DEV_DEBUG_OUTPUT_IRQ_EN
    logic drained_set;
    logic irq_q;

    assign drained_set = pop && (count == CW'(1)) && !push_ok && !flush;
    assign irq         = irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en  <= 1'b0;
            drained <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= din[CTRL_IRQ_EN];
            end
            if (drained_set) begin
                drained <= 1'b1;
            end else if (rd_status) begin
                drained <= 1'b0;
            end
            irq_q <= irq_en && drained;
        end
    end
`else
    assign irq_en  = 1'b0;
    assign drained = 1'b0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        dout = '0;
        case (addr)
            REG_DATA:   dout = 32'(count);
            REG_CTRL:   dout[CTRL_IRQ_EN] = irq_en;
            REG_STATUS: begin
                dout[ST_EMPTY]             = empty;
                dout[ST_FULL]              = full;
                dout[ST_OVF]               = ovf;
                dout[ST_DRAINED]           = drained;
                dout[ST_COUNT_LSB +: 8]    = 8'(count);
            end
            default:    dout = '0;
        endcase
    end

endmodule

// File: tb/tb_dev_debug_output.sv
// Self-checking bench for dev_debug_output: directed steps then random traffic
// against a queue-based model; irq steps are built only with DEV_DEBUG_OUTPUT_IRQ_EN.
module tb_dev_debug_output;

    localparam int DEPTH = 8;
`ifdef DEV_DEBUG_OUTPUT_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] din = '0;
    logic        out_ready = 1'b0;
    logic [31:0] dout;
    logic [31:0] out_data;
    logic        out_valid;
    logic        irq;

    always #5 clk = ~clk;

    dev_debug_output #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .we        (we),
        .re        (re),
        .din       (din),
        .dout      (dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .irq       (irq)
    );

    // scoreboard / reference model
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    bit          m_ovf;
    bit          m_drained;
    bit          m_irq_en;
    bit          m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_dout(input logic [1:0] a);
        int n = exp_q.size();
        int v = 0;
        case (a)
            2'd0:    v = n;
            2'd1:    v = int'(m_irq_en);
            2'd2:    v = n * 256 + int'(m_drained) * 8 + int'(m_ovf) * 4
                         + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic model_step();
        int n      = exp_q.size();
        bit pop    = (n > 0) && out_ready;
        bit push   = we && (addr == 2'd0);
        bit fl     = we && (addr == 2'd1) && din[1];
        bit rd     = re && (addr == 2'd2);
        bit acc    = 1'b0;
        bit ovf_set = 1'b0;
        bit dr_set = 1'b0;
        bit irq_nxt = m_irq_en && m_drained;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0; m_drained = 0; m_irq_en = 0; m_irq = 0;
            return;
        end
        if (fl) begin
            exp_q.delete();
        end else begin
            acc     = push && (n < DEPTH || pop);
            ovf_set = push && !acc;
            dr_set  = pop && (n == 1) && !acc;
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(din);
        end
        m_ovf     = fl ? 1'b0 : ovf_set ? 1'b1 : rd ? 1'b0 : m_ovf;
        m_drained = IRQ_BUILD && (dr_set ? 1'b1 : rd ? 1'b0 : m_drained);
        if (IRQ_BUILD && we && addr == 2'd1) m_irq_en = din[0];
        m_irq     = IRQ_BUILD && irq_nxt;
    endtask

    task automatic check_comb();
        check("dout", dout, model_dout(addr));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    // driver tasks
    task automatic set_in(input logic w, input logic r, input logic [1:0] a,
                          input logic [31:0] d, input logic rdy);
        we = w; re = r; addr = a; din = d; out_ready = rdy;
        #1;
    endtask

    task automatic cycle();
        if (!rst) check_comb();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        w;
        logic        r;
        logic        rdy;
        logic [1:0]  a;
        logic [31:0] d;

        rst = 1'b1;
        set_in(0, 0, 2'd0, 0, 0);
        cycle();
        cycle();
        rst = 1'b0;

        set_in(0, 0, 2'd2, 0, 0);
        check("reset_status", dout, 32'h1);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_data", out_data, 0);
        check("reset_irq", 32'(irq), 0);
        cycle();

        set_in(1, 0, 2'd0, 32'h12345678, 0);
        cycle();
        set_in(0, 0, 2'd0, 0, 0);
        check("push_valid", 32'(out_valid), 1);
        check("push_data", out_data, 32'h12345678);
        check("push_count", dout, 1);
        cycle();

        set_in(1, 0, 2'd1, 32'h2, 0);
        cycle();
        for (int i = 1; i <= 9; i++) begin
            set_in(1, 0, 2'd0, 32'(i), 0);
            cycle();
        end
        set_in(0, 0, 2'd2, 0, 0);
        check("status_full_ovf", dout, 32'h806);
        cycle();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 2'd0, 0, 1);
            cycle();
        end
        set_in(0, 1, 2'd2, 0, 0);
        check("drain_valid", 32'(out_valid), 0);
        cycle();

        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 2'd0, 32'hA000_0000 + 32'(i), 0);
            cycle();
        end
        set_in(1, 0, 2'd0, 32'h87654321, 1);
        cycle();
        set_in(0, 0, 2'd2, 0, 0);
        check("full_pop_push_status", dout, 32'h802);
        cycle();
        for (int i = 0; i < 7; i++) begin
            set_in(0, 0, 2'd0, 0, 1);
            cycle();
        end
        set_in(0, 0, 2'd0, 0, 1);
        check("last_word", out_data, 32'h87654321);
        cycle();
        set_in(0, 1, 2'd2, 0, 0);
        cycle();

`ifdef DEV_DEBUG_OUTPUT_IRQ_EN
        set_in(1, 0, 2'd1, 32'h1, 0);
        cycle();
        set_in(1, 0, 2'd0, 32'd11, 0);
        cycle();
        set_in(1, 0, 2'd0, 32'd22, 0);
        cycle();
        set_in(0, 0, 2'd0, 0, 1);
        cycle();
        set_in(0, 0, 2'd0, 0, 1);
        cycle();
        check("irq_not_yet", 32'(irq), 0);
        cycle();
        check("irq_rise", 32'(irq), 1);
        set_in(0, 1, 2'd2, 0, 1);
        check("status_drained", dout & 32'h8, 32'h8);
        cycle();
        set_in(0, 0, 2'd0, 0, 0);
        cycle();
        check("irq_fall", 32'(irq), 0);
        set_in(1, 0, 2'd1, 32'h0, 0);
        cycle();
`endif

        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 2'd0, 32'hC0DE_0000 + 32'(i), 0);
            cycle();
        end
        set_in(1, 0, 2'd1, 32'h2, 1);
        cycle();
        set_in(0, 0, 2'd2, 0, 0);
        check("flush_status", dout, 32'h1);
        check("flush_valid", 32'(out_valid), 0);
        cycle();
        cycle();
        check("flush_irq", 32'(irq), 0);

        set_in(1, 0, 2'd0, 32'hBEEF_0001, 0);
        cycle();
        set_in(1, 0, 2'd0, 32'hBEEF_0002, 0);
        cycle();
        rst = 1'b1;
        set_in(0, 0, 2'd0, 0, 1);
        cycle();
        rst = 1'b0;
        set_in(0, 0, 2'd2, 0, 0);
        check("rst_mid_status", dout, 32'h1);
        check("rst_mid_valid", 32'(out_valid), 0);
        cycle();

        for (int i = 0; i < 500; i++) begin
            w   = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            d   = $urandom;
            if (a == 2'd1) d[1] = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 3) == 0);
            rdy = (i < 250) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
            set_in(w, r, a, d, rdy);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
